// File: rtl/ncc_engine_if.sv
// Handshake and result bus between the window fetch logic, descriptor loader and the NCC engine.
`timescale 1ns/1ps
interface ncc_engine_if;
    logic                   window_data_ready;
    logic                   desc_data_ready;
    logic [31:0]            descIn;
    logic [15:0][15:0][7:0] windowIn;
    logic                   done_with_window_data;
    logic                   done_with_desc_data;
    logic [31:0]            greatestNCC;
    logic [8:0]             greatestWinIndex;
    logic [31:0]            num;
    logic [31:0]            denom;
    logic [15:0][31:0]      accRowTotal;

    modport master (
        output window_data_ready, desc_data_ready, descIn, windowIn,
        input  done_with_window_data, done_with_desc_data, greatestNCC, greatestWinIndex,
               num, denom, accRowTotal
    );

    modport slave (
        input  window_data_ready, desc_data_ready, descIn, windowIn,
        output done_with_window_data, done_with_desc_data, greatestNCC, greatestWinIndex,
               num, denom, accRowTotal
    );
endinterface

// File: rtl/ncc_engine.sv
// Squared-NCC search of 16x16 windows against a serially loaded 16x16 descriptor (NCC_DEBUG_EN drives debug outputs).
// Latency: window result committed 36 cycles after acceptance; descriptor done one cycle after word 63.
// Backpressure: none; window pulses while busy or before a descriptor is loaded are dropped.
`timescale 1ns/1ps
module ncc_engine (
    input  logic        clk,
    input  logic        rst,
    ncc_engine_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_SUM, S_MUL, S_DIV, S_COMMIT} state_t;
    localparam logic [31:0] SCORE_ONE = 32'h0001_0000;

    state_t                 state, state_nxt;
    logic [15:0][15:0][7:0] desc_ram;
    logic [15:0][15:0][7:0] win_q;
    logic [5:0]             wr_ptr;
    logic [23:0]            sos_acc, desc_sos;
    logic                   desc_valid;
    logic [17:0]            desc_sq4;
    logic [15:0][20:0]      row_tot, row_nxt;
    logic [23:0]            patch_sum, patch_nxt, win_sos, win_sos_nxt;
    logic [47:0]            patch_sq, sos_prod;
    logic [31:0]            num_w, denom_w, denom_q;
    logic [31:0]            rem_q, dvd_q, quo_q, rem_nxt, score;
    logic [32:0]            trial, diff;
    logic                   qbit;
    logic [4:0]             div_cnt;
    logic [31:0]            best_ncc;
    logic [8:0]             best_idx, win_cnt;
    logic                   win_done, desc_done;
    logic                   win_accept, desc_accept;
`ifdef NCC_DEBUG_EN
    logic [31:0]            num_q;
`endif

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        return {8'd0, a} * {8'd0, b};
    endfunction

    always_comb begin
        win_accept  = (state == S_IDLE) && bus.window_data_ready && desc_valid;
        desc_accept = (state == S_IDLE) && bus.desc_data_ready;
        state_nxt   = state;
        case (state)
            S_IDLE:   if (win_accept) state_nxt = S_ROW;
            S_ROW:    state_nxt = S_SUM;
            S_SUM:    state_nxt = S_MUL;
            S_MUL:    state_nxt = S_DIV;
            S_DIV:    if (div_cnt == 5'd31) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        row_nxt     = '0;
        win_sos_nxt = '0;
        patch_nxt   = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                row_nxt[r]  = row_nxt[r] + 21'(mul8(desc_ram[r][c], win_q[r][c]));
                win_sos_nxt = win_sos_nxt + 24'(mul8(win_q[r][c], win_q[r][c]));
            end
            patch_nxt = patch_nxt + 24'(row_tot[r]);
        end
        desc_sq4 = '0;
        for (int i = 0; i < 4; i++)
            desc_sq4 = desc_sq4 + 18'(mul8(bus.descIn[8*i +: 8], bus.descIn[8*i +: 8]));
        patch_sq = {24'd0, patch_sum} * {24'd0, patch_sum};
        sos_prod = {24'd0, desc_sos} * {24'd0, win_sos};
        num_w    = 32'(patch_sq >> 16);
        denom_w  = 32'(sos_prod >> 16);
        // One restoring-division step; the remainder never exceeds the divisor width.
        trial    = {rem_q, dvd_q[31]};
        diff     = trial - {1'b0, denom_q};
        qbit     = (trial >= {1'b0, denom_q});
        rem_nxt  = qbit ? 32'(diff) : 32'(trial);
        if (denom_q == '0)
            score = '0;
        else if (quo_q > SCORE_ONE)
            score = SCORE_ONE;
        else
            score = quo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            desc_ram   <= '0;
            win_q      <= '0;
            wr_ptr     <= '0;
            sos_acc    <= '0;
            desc_sos   <= '0;
            desc_valid <= 1'b0;
            row_tot    <= '0;
            patch_sum  <= '0;
            win_sos    <= '0;
            denom_q    <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            div_cnt    <= '0;
            best_ncc   <= '0;
            best_idx   <= '0;
            win_cnt    <= '0;
            win_done   <= 1'b0;
            desc_done  <= 1'b0;
`ifdef NCC_DEBUG_EN
            num_q      <= '0;
`endif
        end else begin
            desc_done <= 1'b0;
            win_done  <= 1'b0;
            if (desc_accept) begin
                for (int i = 0; i < 4; i++)
                    desc_ram[wr_ptr[5:2]][{wr_ptr[1:0], 2'b00} + 4'(i)] <= bus.descIn[31 - 8*i -: 8];
                wr_ptr  <= wr_ptr + 6'd1;
                // Sum of squares accumulates as words arrive, so no full-patch pass is needed.
                sos_acc <= (wr_ptr == 6'd0) ? 24'(desc_sq4) : sos_acc + 24'(desc_sq4);
                if (wr_ptr == 6'd63) begin
                    desc_done  <= 1'b1;
                    desc_sos   <= sos_acc + 24'(desc_sq4);
                    desc_valid <= 1'b1;
                    best_ncc   <= '0;
                    best_idx   <= '0;
                    win_cnt    <= '0;
                end
            end
            case (state)
                S_IDLE: if (win_accept) win_q <= bus.windowIn;
                S_ROW:  row_tot <= row_nxt;
                S_SUM: begin
                    patch_sum <= patch_nxt;
                    win_sos   <= win_sos_nxt;
                end
                S_MUL: begin
`ifdef NCC_DEBUG_EN
                    num_q   <= num_w;
`endif
                    denom_q <= denom_w;
                    rem_q   <= {16'd0, num_w[31:16]};
                    dvd_q   <= {num_w[15:0], 16'd0};
                    quo_q   <= '0;
                    div_cnt <= '0;
                end
                S_DIV: begin
                    rem_q   <= rem_nxt;
                    dvd_q   <= {dvd_q[30:0], 1'b0};
                    quo_q   <= {quo_q[30:0], qbit};
                    div_cnt <= div_cnt + 5'd1;
                end
                S_COMMIT: begin
                    if (score > best_ncc) begin
                        best_ncc <= score;
                        best_idx <= win_cnt;
                    end
                    win_cnt  <= win_cnt + 9'd1;
                    win_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done_with_window_data = win_done;
    assign bus.done_with_desc_data   = desc_done;
    assign bus.greatestNCC           = best_ncc;
    assign bus.greatestWinIndex      = best_idx;

`ifdef NCC_DEBUG_EN
    assign bus.num   = num_q;
    assign bus.denom = denom_q;
    for (genvar r = 0; r < 16; r++) begin : g_row
        assign bus.accRowTotal[r] = {11'd0, row_tot[r]};
    end
`else
    assign bus.num         = '0;
    assign bus.denom       = '0;
    assign bus.accRowTotal = '0;
`endif
endmodule

// File: tb/tb_ncc_engine.sv
// Scoreboard bench for ncc_engine: directed windows with hand-computed scores, checked on done pulses.
`timescale 1ns/1ps
module tb_ncc_engine;
    typedef struct {
        int unsigned cyc;
        logic [31:0] ncc;
        logic [8:0]  idx;
        logic [31:0] num;
        logic [31:0] den;
        logic [31:0] row;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_win[$];
    int unsigned exp_desc[$];

    logic [15:0][15:0][7:0] w2s, wpat, wzero;

    ncc_engine_if bus();
    ncc_engine u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dbg(input logic [31:0] v);
`ifdef NCC_DEBUG_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic load_desc(input logic [31:0] w);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 32) begin
                // Gap with garbage on the bus: pointer must hold.
                bus.desc_data_ready = 1'b0;
                bus.descIn = 32'hFFFF_FFFF;
                repeat (3) @(negedge clk);
            end
            bus.desc_data_ready = 1'b1;
            bus.descIn = w;
            if (k == 63) exp_desc.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.desc_data_ready = 1'b0;
        bus.descIn = '0;
    endtask

    task automatic send_win(input logic [15:0][15:0][7:0] w, input bit commit,
                            input exp_t e, output int unsigned t);
        @(negedge clk);
        bus.windowIn = w;
        bus.window_data_ready = 1'b1;
        t = cyc + 1;
        if (commit) begin
            e.cyc = t + 36;
            exp_win.push_back(e);
        end
        @(negedge clk);
        bus.window_data_ready = 1'b0;
        bus.windowIn = '0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t m;
        int unsigned dc;
        if (bus.done_with_desc_data === 1'b1) begin
            if (exp_desc.size() == 0) unexpected("desc_done");
            else begin
                dc = exp_desc.pop_front();
                check("desc_done_cycle", cyc, dc);
            end
        end
        if (bus.done_with_window_data === 1'b1) begin
            if (exp_win.size() == 0) unexpected("win_done");
            else begin
                m = exp_win.pop_front();
                check("win_done_cycle", cyc, m.cyc);
                check("greatestNCC", bus.greatestNCC, m.ncc);
                check("greatestWinIndex", {23'd0, bus.greatestWinIndex}, {23'd0, m.idx});
                check("num", bus.num, m.num);
                check("denom", bus.denom, m.den);
                check("accRowTotal0", bus.accRowTotal[0], m.row);
                check("accRowTotal15", bus.accRowTotal[15], m.row);
            end
        end
    end

    initial begin : stim
        exp_t e;
        int unsigned t;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                w2s[r][c]   = 8'd2;
                wpat[r][c]  = 8'(3 + (c % 4));
                wzero[r][c] = 8'd0;
            end
        bus.window_data_ready = 1'b0;
        bus.desc_data_ready = 1'b0;
        bus.descIn = '0;
        bus.windowIn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ncc", bus.greatestNCC, 32'd0);
        check("rst_idx", {23'd0, bus.greatestWinIndex}, 32'd0);
        check("rst_win_done", {31'd0, bus.done_with_window_data}, 32'd0);
        check("rst_desc_done", {31'd0, bus.done_with_desc_data}, 32'd0);
        check("rst_num", bus.num, 32'd0);
        check("rst_row0", bus.accRowTotal[0], 32'd0);

        // Window before any descriptor: dropped, no done pulse.
        e = '{0, 32'd0, 9'd0, 32'd0, 32'd0, 32'd0};
        send_win(w2s, 1'b0, e, t);
        wait_cyc(t + 45);
        check("nodesc_ncc", bus.greatestNCC, 32'd0);

        load_desc(32'h0304_0506);
        repeat (2) @(negedge clk);

        // Window 0 (all 2s) with a busy pulse at T+10.
        e = '{0, 32'd61725, 9'd0, dbg(32'd81), dbg(32'd86), dbg(32'd144)};
        send_win(w2s, 1'b1, e, t);
        wait_cyc(t + 1);
        check("row0_at_T1", bus.accRowTotal[0], dbg(32'd144));
        wait_cyc(t + 3);
        check("num_at_T3", bus.num, dbg(32'd81));
        check("denom_at_T3", bus.denom, dbg(32'd86));
        wait_cyc(t + 9);
        bus.windowIn = wzero;
        bus.window_data_ready = 1'b1;
        @(negedge clk);
        bus.window_data_ready = 1'b0;
        wait_cyc(t + 40);

        e = '{0, 32'd65536, 9'd1, dbg(32'd462), dbg(32'd462), dbg(32'd344)};
        send_win(wpat, 1'b1, e, t);
        wait_cyc(t + 40);

        e = '{0, 32'd65536, 9'd1, 32'd0, 32'd0, 32'd0};
        send_win(wzero, 1'b1, e, t);
        wait_cyc(t + 40);

        e = '{0, 32'd65536, 9'd1, dbg(32'd81), dbg(32'd86), dbg(32'd144)};
        send_win(w2s, 1'b1, e, t);
        wait_cyc(t + 40);

        // Reload clears best score and window counter.
        load_desc(32'h0304_0506);
        repeat (2) @(negedge clk);
        check("reload_ncc", bus.greatestNCC, 32'd0);
        check("reload_idx", {23'd0, bus.greatestWinIndex}, 32'd0);
        e = '{0, 32'd61725, 9'd0, dbg(32'd81), dbg(32'd86), dbg(32'd144)};
        send_win(w2s, 1'b1, e, t);
        wait_cyc(t + 40);

        // Reset mid-window at T+20: no commit, outputs cleared.
        e = '{0, 32'd0, 9'd0, 32'd0, 32'd0, 32'd0};
        send_win(w2s, 1'b0, e, t);
        wait_cyc(t + 19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ncc", bus.greatestNCC, 32'd0);
        check("midrst_idx", {23'd0, bus.greatestWinIndex}, 32'd0);
        check("midrst_num", bus.num, 32'd0);
        check("midrst_denom", bus.denom, 32'd0);
        check("midrst_row0", bus.accRowTotal[0], 32'd0);
        repeat (45) @(negedge clk);
        send_win(w2s, 1'b0, e, t);
        wait_cyc(t + 45);
        check("postrst_ncc", bus.greatestNCC, 32'd0);

        load_desc(32'h0304_0506);
        e = '{0, 32'd61725, 9'd0, dbg(32'd81), dbg(32'd86), dbg(32'd144)};
        send_win(w2s, 1'b1, e, t);
        wait_cyc(t + 40);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_win.size() + exp_desc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ncc_engine.md
# ncc_engine

Normalized cross-correlation (NCC) search engine for the vision pipeline. Holds one 16x16 8-bit descriptor patch, loaded serially four bytes per cycle. It scores each 16x16 candidate window presented in parallel against that patch and tracks the best-scoring window. The score is squared NCC in unsigned Q16 (0x00010000 = perfect match); the block sits between the window fetch logic and the feature matcher.

## Interface
- No parameters; patch fixed at 16x16, 8-bit pixels.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- window_data_ready  in  1  one-cycle pulse; windowIn valid this cycle.
- desc_data_ready  in  1  descIn valid this cycle (descriptor load strobe).
- descIn  in  32  four descriptor pixels; [31:24] lowest column.
- windowIn  in  8 x [16][16]  candidate window, [row][col], unsigned.
- done_with_window_data  out  1  one-cycle pulse: window result committed, engine idle.
- done_with_desc_data  out  1  one-cycle pulse: 64th descriptor word stored.
- greatestNCC  out  32  best score so far, Q16 unsigned.
- greatestWinIndex  out  9  index of best window.
- num  out  32  debug: last squared numerator >> 16.
- denom  out  32  debug: last denominator >> 16.
- accRowTotal  out  32 x [16]  debug: per-row sum of d*w for last window.

## Operation
- Descriptor load: each cycle desc_data_ready=1 stores descIn as word k (0..63) → row k/4, cols 4*(k%4)..+3, [31:24] at col 4*(k%4). Word pointer holds while strobe low; extra words after 64 ignored until pointer wraps on completion.
- On word 63: pulse done_with_desc_data, compute descSumOfSquares (Σd², 24 bits), set desc_valid, clear greatestNCC, greatestWinIndex, window counter.
- Window: accepted only if desc_valid and idle; otherwise pulse ignored. windowIn registered on acceptance.
- Arithmetic (unsigned, no overflow): accRowTotal[r]=Σc d*w (21 bits used); accPatchSum=Σ rows (24 bits); winSumOfSquares=Σw² (24 bits); num=(accPatchSum²)>>16; denom=(descSOS*winSOS)>>16; score=(num<<16)/denom via 32-iteration restoring divider, truncated, saturated to 0x00010000; denom=0 → score 0.
- Commit: if score > greatestNCC (strict), greatestNCC←score, greatestWinIndex←window counter. Counter then increments, 9-bit, wraps 511→0.
- States: IDLE → ROW (row totals) → SUM → MUL → DIV (32 cycles) → COMMIT → IDLE.

## Timing
- Reset: all outputs 0, descriptor RAM 0, desc_valid 0, pointer/counter 0, state IDLE. Reset mid-load or mid-window aborts with no commit.
- done_with_desc_data high the cycle after the edge sampling word 63.
- Window sampled at edge T: accRowTotal valid after T+1, sums after T+2, num/denom after T+3, divider done T+35, greatestNCC/greatestWinIndex updated and done_with_window_data high after edge T+36 for one cycle. Next window accepted from that cycle.
- Descriptor strobe while a window is in flight: ignored.
- num, denom, accRowTotal hold until next window.

## Configuration
- NCC_DEBUG_EN defined: num, denom, accRowTotal driven from internal registers as above.
- Undefined: those outputs tied to 0; scoring unaffected.

## Test plan
- Reset, load 64 words 0x03040506, window all 2s, pulse → accRowTotal[*]=144, accPatchSum=2304, descSOS=5504, winSOS=1024, num=81, denom=86, greatestNCC=61725, greatestWinIndex=0, done pulse at T+36.
- Same descriptor, window equal to descriptor pattern (rows 3,4,5,6 repeated) as window 1 → score 65536, greatestWinIndex=1.
- Window pulse before any descriptor load → ignored, no done pulse, outputs 0.
- All-zero window → denom 0, score 0, greatestNCC unchanged.
- Second window pulse at T+10 while busy → ignored, counter advances once only.
- Assert rst at T+20 → all outputs 0, no done pulse; reload descriptor clears best.
